regfile_exec: RTL and testbench
===============================

REGFILE_EXEC -- requirements
Module: regfile_exec

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the register and operand width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register address width (32 registers).
REQ-003 SHALL use one clock, clk, with reset rst_n; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to execute one instruction; sampled only in IDLE.
REQ-007 rs_addr, rt_addr, rd_addr  input  ADDR_W each  source A, source B and destination register.
REQ-008 op_in  input  3  ALU operation code: 0 and, 1 or, 2 xor, 3 nor, 4 add, 5 sub, 6 slt, 7 sll.
REQ-009 wr_en, wr_addr, wr_data  input  1/ADDR_W/DATA_W  direct preload write port.
REQ-010 alu_a, alu_b  output  DATA_W each  registered operands to the downstream ALU.
REQ-011 alu_op  output  3  registered operation code to the ALU.
REQ-012 alu_f, alu_zf, alu_of  input  DATA_W/1/1  combinational ALU result and flags.
REQ-013 busy  output  1  high in READ, EXEC and WB.
REQ-014 done  output  1  one-cycle pulse in WB.
REQ-015 zf_q, of_q  output  1 each  flags of the last completed instruction.
REQ-016 dbg_addr  input  ADDR_W; dbg_data  output  DATA_W  combinational register read.

Function
REQ-017 SHALL use an FSM with states IDLE, READ, EXEC and WB, and SHALL advance one state per clock.
REQ-018 IDLE with start=1: latch rs_addr, rt_addr, rd_addr and op_in; next state READ; otherwise remain in IDLE.
REQ-019 READ: alu_a <= rf[rs], alu_b <= rf[rt], alu_op <= latched op; next state EXEC.
REQ-020 EXEC: capture alu_f, alu_zf and alu_of into internal result registers; next state WB.
REQ-021 WB: rf[rd] <= result unless rd=0; zf_q/of_q <= captured flags; done=1; next state IDLE.
REQ-022 Latency: start sampled at edge N -> done high in the cycle after edge N+3; throughput is one instruction per 4 cycles.
REQ-023 start while busy SHALL be ignored, with no queuing.
REQ-024 Register 0 SHALL read as 0 on every port; writes to register 0 SHALL be discarded from both the preload port and write-back.
REQ-025 wr_en SHALL take effect only in IDLE and SHALL be ignored while busy.
REQ-026 Simultaneous wr_en and start in IDLE: the write SHALL commit at that edge, start SHALL be accepted, and READ SHALL see the new value.
REQ-027 rd equal to rs or rt: READ SHALL use the old value; the new value SHALL be visible from the next instruction.
REQ-028 An overflowing add/sub result SHALL be written back unmodified, with of_q=1; no trap.
REQ-029 dbg_data SHALL reflect a write-back from the edge after the WB cycle.
REQ-030 alu_a, alu_b and alu_op SHALL hold their values outside READ.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, all 32 registers 0, and alu_a, alu_b, alu_op, busy, done, zf_q, of_q and the latched fields to 0.
REQ-032 Reset mid-instruction SHALL abort the instruction with no write-back and no done pulse; the first start after release SHALL behave normally.

Verification
REQ-033 Preload r1=0x7FFFFFFF, r2=0x00000001; start rs=1 rt=2 rd=3 op=4 -> done 4 cycles later; r3=0x80000000; of_q=1; zf_q=0.
REQ-034 Preload r4=0x12345678, r5=0x12345678; op=5, rd=6 -> r6=0; zf_q=1; of_q=0.
REQ-035 Start with rd=0 and op=3 on r0,r0 (result 0xFFFFFFFF) -> dbg read of r0 returns 0; done still pulses.
REQ-036 Pulse start again during busy, and pulse wr_en to r7 during busy -> the second start is ignored; r7 is unchanged; exactly one done pulse.
REQ-037 Same-cycle wr_en r8=0x3 and start rs=8 rt=9 (r9=0x607) rd=8 op=7 -> alu_a=0x3; r8=0x3038.
REQ-038 Assert rst_n=0 in the EXEC cycle -> no done pulse; rd unchanged (0); busy=0 immediately.

Source files
------------

// File: rtl/regfile_exec.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// regfile_exec
//
// Register file plus a four-state sequencer that runs one instruction at a
// time through an external combinational ALU:
//   IDLE -> READ -> EXEC -> WB -> IDLE
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      execute request, sampled only in IDLE
//   rs_addr, rt_addr, rd_addr  source A, source B, destination register
//   op_in                      ALU op: and, or, xor, nor, add, sub, slt, sll
//   wr_en, wr_addr, wr_data    preload write port, honoured only in IDLE
//   alu_a, alu_b, alu_op       registered operands / op to the ALU
//   alu_f, alu_zf, alu_of      ALU result and flags (combinational)
//   busy                       high in READ, EXEC and WB
//   done                       one-cycle pulse after the WB edge
//   zf_q, of_q                 flags of the last completed instruction
//   dbg_addr, dbg_data         combinational debug read of the register file
// ---------------------------------------------------------------------------
module regfile_exec #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        op_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_zf,
    input  logic              alu_of,
    output logic              busy,
    output logic              done,
    output logic              zf_q,
    output logic              of_q,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched instruction fields
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic [ADDR_W-1:0] r_rd;
    logic [2:0]        r_op;

    // ALU operand registers
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_op;

    // Result captured in EXEC, committed in WB
    logic [DATA_W-1:0] r_res;
    logic              r_zf;
    logic              r_of;

    logic              r_done;
    logic              r_zf_q;
    logic              r_of_q;

    // Register file read view; element 0 is tied to zero
    logic [DATA_W-1:0] w_rf [NREG];

    logic w_pre_we;
    logic w_wb_we;

    // Preload only while idle; write-back only in WB. The two can never
    // collide because they are qualified by different states.
    assign w_pre_we = (r_state == S_IDLE) && wr_en;
    assign w_wb_we  = (r_state == S_WB);

    // -----------------------------------------------------------------------
    // Register file: one flop bank per register so every entry can be
    // cleared by the asynchronous reset. Register 0 has no storage at all,
    // which discards writes and makes every read port return zero.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_rf[gi] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_pre_we && (wr_addr == ADDR_W'(gi))) begin
                        r_q <= wr_data;
                    end else if (w_wb_we && (r_rd == ADDR_W'(gi))) begin
                        r_q <= r_res;
                    end
                end
                assign w_rf[gi] = r_q;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state: one state per clock once started
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_READ : S_IDLE;
            S_READ:  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WB;
            S_WB:    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_op     <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_res    <= '0;
            r_zf     <= 1'b0;
            r_of     <= 1'b0;
            r_zf_q   <= 1'b0;
            r_of_q   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // done rises together with the write-back becoming visible
            r_done <= (r_state == S_WB);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rs <= rs_addr;
                        r_rt <= rt_addr;
                        r_rd <= rd_addr;
                        r_op <= op_in;
                    end
                end
                S_READ: begin
                    // A preload in the same cycle as start has already
                    // committed, so this read sees the new value.
                    r_alu_a  <= w_rf[r_rs];
                    r_alu_b  <= w_rf[r_rt];
                    r_alu_op <= r_op;
                end
                S_EXEC: begin
                    r_res <= alu_f;
                    r_zf  <= alu_zf;
                    r_of  <= alu_of;
                end
                S_WB: begin
                    r_zf_q <= r_zf;
                    r_of_q <= r_of;
                end
                default: ;
            endcase
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign zf_q     = r_zf_q;
    assign of_q     = r_of_q;
    assign dbg_data = w_rf[dbg_addr];

endmodule

// File: tb/tb_regfile_exec.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_regfile_exec
//
// Directed bench for regfile_exec. The bench supplies the combinational ALU,
// keeps a register-file model, pushes the expected result of each accepted
// instruction into a queue and pops it when done pulses.
// ---------------------------------------------------------------------------
module tb_regfile_exec;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] rs_addr, rt_addr, rd_addr;
    logic [2:0]    op_in;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] alu_a, alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_f;
    logic          alu_zf, alu_of;
    logic          busy, done, zf_q, of_q;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m [32];

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] f;
        logic          z;
        logic          o;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    regfile_exec #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .op_in    (op_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_f    (alu_f),
        .alu_zf   (alu_zf),
        .alu_of   (alu_of),
        .busy     (busy),
        .done     (done),
        .zf_q     (zf_q),
        .of_q     (of_q),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Reference ALU: returns {f, zf, of}
    function automatic logic [DW+1:0] alu_calc(input logic [2:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] f;
        logic          o;
        o = 1'b0;
        case (op)
            3'd0: f = a & b;
            3'd1: f = a | b;
            3'd2: f = a ^ b;
            3'd3: f = ~(a | b);
            3'd4: begin f = a + b; o = (a[DW-1] == b[DW-1]) && (f[DW-1] != a[DW-1]); end
            3'd5: begin f = a - b; o = (a[DW-1] != b[DW-1]) && (f[DW-1] != a[DW-1]); end
            3'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: f = b << a[4:0];
        endcase
        return {f, (f == '0), o};
    endfunction

    always_comb begin
        {alu_f, alu_zf, alu_of} = alu_calc(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
        if (a != '0) m[a] = d;
        $display("preload r%0d=%h", a, d);
    endtask

    task automatic read_reg(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Pop the oldest expectation and compare the architectural results.
    task automatic check_done();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        read_reg("wb_data", e.rd, (e.rd == '0) ? '0 : e.f);
        chk("zf_q", 32'(zf_q), 32'(e.z));
        chk("of_q", 32'(of_q), 32'(e.o));
        chk("alu_a_hold", alu_a, e.a);
        if (e.rd != '0) m[e.rd] = e.f;
        $display("txn rd=r%0d f=%h zf=%0d of=%0d", e.rd, e.f, e.z, e.o);
    endtask

    task automatic push_exp(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                            input logic [AW-1:0] rd, input logic [2:0] op);
        exp_t e;
        logic [DW+1:0] r;
        e.a  = m[rs];
        e.b  = m[rt];
        r    = alu_calc(op, e.a, e.b);
        e.f  = r[DW+1:2];
        e.z  = r[1];
        e.o  = r[0];
        e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic run_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                             input logic [AW-1:0] rd, input logic [2:0] op,
                             input bit with_wr, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd);
        int n;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
            if (wa != '0) m[wa] = wd;
        end
        push_exp(rs, rt, rd, op);
        rs_addr = rs;
        rt_addr = rt;
        rd_addr = rd;
        op_in   = op;
        start   = 1'b1;
        step();                         // edge N: READ
        start = 1'b0;
        wr_en = 1'b0;
        chk("busy_read", 32'(busy), 32'd1);
        step();                         // edge N+1: EXEC, operands loaded
        chk("alu_a", alu_a, m[rs]);
        chk("alu_b", alu_b, m[rt]);
        chk("alu_op", 32'(alu_op), 32'(op));
        n = 0;
        while (done !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd2);  // done after edge N+3
        check_done();
        step();
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        for (int i = 0; i < 32; i++) m[i] = '0;
        rst_n    = 1'b0;
        start    = 1'b0;
        rs_addr  = '0;
        rt_addr  = '0;
        rd_addr  = '0;
        op_in    = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        dbg_addr = '0;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_zf", 32'(zf_q), 32'd0);
        read_reg("rst_r1", 5'd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Add with signed overflow
        preload(5'd1, 32'h7FFF_FFFF);
        preload(5'd2, 32'h0000_0001);
        run_instr(5'd1, 5'd2, 5'd3, 3'd4, 1'b0, '0, '0);

        // Equal subtract gives zero
        preload(5'd4, 32'h1234_5678);
        preload(5'd5, 32'h1234_5678);
        run_instr(5'd4, 5'd5, 5'd6, 3'd5, 1'b0, '0, '0);

        // Write-back to r0 discarded, done still pulses
        run_instr(5'd0, 5'd0, 5'd0, 3'd3, 1'b0, '0, '0);
        preload(5'd0, 32'hFFFF_0000);
        read_reg("r0_preload", 5'd0, 32'd0);

        // Destination equals source: READ sees old value, next sees new
        run_instr(5'd3, 5'd2, 5'd3, 3'd4, 1'b0, '0, '0);
        run_instr(5'd3, 5'd0, 5'd25, 3'd1, 1'b0, '0, '0);

        // start and wr_en while busy are ignored
        preload(5'd7, 32'h0000_0077);
        push_exp(5'd4, 5'd1, 5'd15, 3'd0);
        rs_addr = 5'd4; rt_addr = 5'd1; rd_addr = 5'd15; op_in = 3'd0;
        start = 1'b1;
        step();                         // READ
        start = 1'b0;
        step();                         // EXEC
        start   = 1'b1;
        rd_addr = 5'd16;
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hDEAD_BEEF;
        step();                         // WB
        start = 1'b0;
        wr_en = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) check_done();
            end
        end
        chk("one_done", 32'(ndone), 32'd1);
        read_reg("r7_kept", 5'd7, 32'h0000_0077);
        read_reg("r16_kept", 5'd16, 32'd0);

        // Same-cycle preload and start, shift left
        preload(5'd9, 32'h0000_0607);
        run_instr(5'd8, 5'd9, 5'd8, 3'd7, 1'b1, 5'd8, 32'h0000_0003);
        read_reg("r8_sll", 5'd8, 32'h0000_3038);

        // All operations on one operand pair
        preload(5'd12, 32'hF0F0_1234);
        preload(5'd13, 32'h0FF0_00FF);
        for (int op = 0; op < 8; op++) begin
            run_instr(5'd12, 5'd13, 5'(17 + op), 3'(op), 1'b0, '0, '0);
        end

        // Reset during EXEC aborts the instruction
        rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd10; op_in = 3'd4;
        start = 1'b1;
        step();                         // READ
        start = 1'b0;
        step();                         // EXEC
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        for (int i = 0; i < 32; i++) m[i] = '0;
        read_reg("abort_r10", 5'd10, 32'd0);
        read_reg("abort_r1", 5'd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        $display("txn aborted by reset");

        // First instruction after reset behaves normally
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd6);
        run_instr(5'd1, 5'd2, 5'd11, 3'd4, 1'b0, '0, '0);
        read_reg("post_rst_r11", 5'd11, 32'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
